// File: rtl/boa_pmu_ctl.sv
`timescale 1ns/1ps
// boa_pmu_ctl: memory-mapped power-management sequencer. It issues key-protected
// shutdown/reset requests after a programmable delay, and has an optional watchdog.
//
//   state     | meaning
//   ST_IDLE   | no request pending
//   ST_COUNT  | delay down-counter running before the request is asserted
//   ST_ASSERT | pmu_shdn or pmu_rst held high for HOLD_CYCLES cycles
module boa_pmu_ctl #(
  parameter int          ADDR_W      = 5,
  parameter logic [31:0] KEY         = 32'h5057_4B59,
  parameter int          HOLD_CYCLES = 16,
  parameter int          WDT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bus_re,
  input  logic [3:0]        bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  output logic              bus_ready,
  output logic              pmu_shdn,
  output logic              pmu_rst
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_ASSERT = 2'd2
  } state_e;

  // The op code doubles as the cause code reported in STATUS.
  localparam logic [1:0] OP_SHDN = 2'b01;
  localparam logic [1:0] OP_RST  = 2'b10;
  localparam logic [1:0] OP_WDT  = 2'b11;

  localparam int              WI_W   = ADDR_W - 2;
  localparam logic [WI_W-1:0] W_KEY  = WI_W'(0);
  localparam logic [WI_W-1:0] W_CMD  = WI_W'(1);
  localparam logic [WI_W-1:0] W_LOAD = WI_W'(2);
  localparam logic [WI_W-1:0] W_KICK = WI_W'(3);
  localparam logic [WI_W-1:0] W_STAT = WI_W'(4);

  localparam int                HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [1:0]        cause_q, cause_d;
  logic [15:0]       dly_q, dly_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              armed_q, armed_d;
  logic [WDT_W-1:0]  wdt_load_q, wdt_load_d;
  logic [WDT_W-1:0]  wdt_cnt_q, wdt_cnt_d;
  logic              ready_q, ready_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              shdn_q, shdn_d;
  logic              rst_q, rst_d;

  logic [WI_W-1:0] widx;
  logic            acc, wr, rd;
  logic            wr_key, wr_cmd, wr_load, wr_kick;
  logic            cmd_go, wdt_active, wdt_expire;
  logic            unused_addr_lsb;

  assign widx            = bus_addr[ADDR_W-1:2];
  assign unused_addr_lsb = ^bus_addr[1:0];

  // A request still present during its own ready cycle must not be taken twice.
  assign acc     = (bus_re | (|bus_we)) & ~ready_q;
  assign wr      = acc & (|bus_we);
  assign rd      = acc & ~(|bus_we);
  assign wr_key  = wr & (widx == W_KEY);
  assign wr_cmd  = wr & (widx == W_CMD);
  assign wr_load = wr & (widx == W_LOAD);
  assign wr_kick = wr & (widx == W_KICK);

  assign cmd_go = wr_cmd & armed_q & (state_q == ST_IDLE) &
                  ((bus_wdata[1:0] == OP_SHDN) | (bus_wdata[1:0] == OP_RST));

  // A reload written in the expiry cycle beats the expiry.
  assign wdt_active = (wdt_load_q != '0) & (state_q != ST_ASSERT);
  assign wdt_expire = wdt_active & (wdt_cnt_q == WDT_W'(1)) & ~(wr_load | wr_kick);

  always_comb begin
    rdata_d = '0;
    ready_d = acc;
    if (rd) begin
      case (widx)
        W_KEY:   rdata_d = {31'b0, armed_q};
        W_LOAD:  rdata_d = 32'(wdt_load_q);
        W_KICK:  rdata_d = 32'(wdt_cnt_q);
        W_STAT:  rdata_d = {27'b0, cause_q, armed_q, state_q};
        default: rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    armed_d = armed_q;
    if (acc) armed_d = wr_key & (bus_wdata == KEY);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cause_d = cause_q;
    dly_d   = dly_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_go) begin
          state_d = ST_COUNT;
          op_d    = bus_wdata[1:0];
          dly_d   = bus_wdata[31:16];
        end
      end
      ST_COUNT: begin
        if (dly_q == '0) begin
          state_d = ST_ASSERT;
          hold_d  = HOLD_LAST;
          cause_d = op_q;
        end else begin
          dly_d = dly_q - 16'd1;
        end
      end
      ST_ASSERT: begin
        if (hold_q == '0) state_d = ST_IDLE;
        else              hold_d  = hold_q - HOLD_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    // Watchdog expiry overrides a pending delay and a same-cycle command.
    if (wdt_expire) begin
      state_d = ST_ASSERT;
      op_d    = OP_WDT;
      cause_d = OP_WDT;
      hold_d  = HOLD_LAST;
    end
  end

  always_comb begin
    wdt_load_d = wdt_load_q;
    wdt_cnt_d  = wdt_cnt_q;
    if (wdt_active && (wdt_cnt_q != '0)) wdt_cnt_d = wdt_cnt_q - WDT_W'(1);
    if ((state_q == ST_ASSERT) && (state_d == ST_IDLE) && (op_q == OP_WDT))
      wdt_cnt_d = wdt_load_q;
    if (wr_load) begin
      wdt_load_d = bus_wdata[WDT_W-1:0];
      wdt_cnt_d  = bus_wdata[WDT_W-1:0];
    end else if (wr_kick) begin
      wdt_cnt_d = wdt_load_q;
    end
  end

  // Request outputs are registered from the next state so they cannot glitch.
  assign shdn_d = (state_d == ST_ASSERT) & (op_d == OP_SHDN);
  assign rst_d  = (state_d == ST_ASSERT) & op_d[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= 2'b00;
      cause_q    <= 2'b00;
      dly_q      <= '0;
      hold_q     <= '0;
      armed_q    <= 1'b0;
      wdt_load_q <= '0;
      wdt_cnt_q  <= '0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      shdn_q     <= 1'b0;
      rst_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cause_q    <= cause_d;
      dly_q      <= dly_d;
      hold_q     <= hold_d;
      armed_q    <= armed_d;
      wdt_load_q <= wdt_load_d;
      wdt_cnt_q  <= wdt_cnt_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      shdn_q     <= shdn_d;
      rst_q      <= rst_d;
    end
  end

  assign bus_ready = ready_q;
  assign bus_rdata = rdata_q;
  assign pmu_shdn  = shdn_q;
  assign pmu_rst   = rst_q;

endmodule
